// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one 8-bit add/subtract datapath.
// Each operation takes three cycles: IDLE (grant and capture), EXEC
// (compute and register the result) and RESP (hold the result until the
// consumer accepts it).
// Optional feature: define ADDSUB_ARB_ROUND_ROBIN_EN for round-robin
// arbitration between the two requesters. When it is undefined, requester 0
// has fixed priority.
module addsub_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [1:0] req_sub,
    output logic [1:0] req_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_s,
    output logic       rsp_carry,
    output logic       rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       gnt_id;
    logic [1:0] gnt_vec;
    logic       hs;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_sub;
    logic       op_id;
    logic [7:0] b_eff;
    logic [8:0] sum;

`ifdef ADDSUB_ARB_ROUND_ROBIN_EN
    logic last_gnt;

    // Arbitration: on contention, grant the requester that was not granted last
    always_comb begin
        gnt_id = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_id = ~last_gnt;
        end else if (req_valid[1]) begin
            gnt_id = 1'b1;
        end
    end

    // Last-grant register. It only moves on a real handshake, so a dropped request leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (hs) begin
            last_gnt <= gnt_id;
        end
    end
`else
    // Arbitration: fixed priority. Requester 1 wins only when it is the sole requester.
    always_comb begin
        gnt_id = ~req_valid[0] & req_valid[1];
    end
`endif

    // Next-state logic, grant and handshake decode
    always_comb begin
        state_nxt = state;
        gnt_vec   = '0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    gnt_vec   = gnt_id ? 2'b10 : 2'b01;
                    hs        = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The ready output is gated by rst_n so that it reads 00 for the whole time reset is held
    assign req_ready = gnt_vec & {2{rst_n}};
    assign rsp_valid = (state == RESP);

    // Shared datapath. Subtraction is computed as a + ~b + 1.
    assign b_eff = op_sub ? ~op_b : op_b;
    assign sum   = {1'b0, op_a} + {1'b0, b_eff} + {8'h00, op_sub};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on handshake. This isolates the in-flight operation from later input changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            op_id  <= 1'b0;
        end else if (hs) begin
            op_a   <= gnt_id ? req1_a : req0_a;
            op_b   <= gnt_id ? req1_b : req0_b;
            op_sub <= req_sub[gnt_id];
            op_id  <= gnt_id;
        end
    end

    // Result registers. They load in EXEC and otherwise hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_s     <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_id    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_s     <= sum[7:0];
            rsp_carry <= sum[8];
            rsp_zero  <= (sum[7:0] == 8'h00);
            rsp_id    <= op_id;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter. Directed cases are checked against
// constant expected values. A transaction-level monitor checks every cycle
// against a queue of expected results, and those results come from plain
// arithmetic. Define ADDSUB_ARB_ROUND_ROBIN_EN for the bench and the DUT alike.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req_sub = '0;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_s;
    logic       rsp_carry;
    logic       rsp_zero;

    int n_cmp = 0;
    int n_bad = 0;

    addsub_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req_sub   (req_sub),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected response packed as {id, zero, carry, s}
    function automatic logic [10:0] model(input int id, input int a, input int b, input bit sub);
        int r;
        int s;
        bit carry;
        r = sub ? (a - b) : (a + b);
        s = r & 255;
        carry = sub ? (a >= b) : (r > 255);
        return {id[0], (s == 0), carry, s[7:0]};
    endfunction

    // Reference arbitration. The result is -1 when nothing is requested.
    int lg = 1;
    function automatic int exp_grant(input logic [1:0] v);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ADDSUB_ARB_ROUND_ROBIN_EN
        return 1 - lg;
`else
        return 0;
`endif
    endfunction

    // Transaction-level monitor
    logic [10:0] q[$];
    logic [10:0] last = '0;
    int cyc = 0;
    int hs_cyc = 0;

    always @(negedge clk) begin
        int g;
        logic [1:0] exp_rdy;
        bit busy, exp_v;
        logic [10:0] ref_v;
        logic [7:0] a, b;
        if (!rst_n) begin
            q.delete();
            last = '0;
            lg = 1;
            chk("mon_rst_ready", req_ready, 2'b00);
            chk("mon_rst_valid", rsp_valid, 1'b0);
        end else begin
            cyc++;
            busy = (q.size() != 0);
            g = busy ? -1 : exp_grant(req_valid);
            exp_rdy = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
            chk("mon_req_ready", req_ready, exp_rdy);
            exp_v = busy && (cyc >= hs_cyc + 2);
            chk("mon_rsp_valid", rsp_valid, exp_v);
            ref_v = exp_v ? q[0] : last;
            chk("mon_rsp_fields", {rsp_id, rsp_zero, rsp_carry, rsp_s}, ref_v);
            if (exp_v && rsp_ready) last = q.pop_front();
            if (g >= 0) begin
                a = (g == 1) ? req1_a : req0_a;
                b = (g == 1) ? req1_b : req0_b;
                q.push_back(model(g, a, b, req_sub[g]));
                hs_cyc = cyc;
                lg = g;
            end
        end
    end

    // One directed operation. rsp_ready is held high. The task starts just after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                          input bit sub, input logic [7:0] es, input bit ec, input bit ez);
        int n;
        rsp_ready = 1'b1;
        if (id == 0) begin req0_a = a; req0_b = b; req_valid = 2'b01; end
        else         begin req1_a = a; req1_b = b; req_valid = 2'b10; end
        req_sub = sub ? 2'b11 : 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 8);
        chk({tag, "_hs_cycles"}, n, 1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom);
        req_sub = ~req_sub;
        @(negedge clk);
        chk({tag, "_lat1_valid"}, rsp_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, rsp_valid, 1'b1);
        chk({tag, "_s"}, rsp_s, es);
        chk({tag, "_carry"}, rsp_carry, ec);
        chk({tag, "_zero"}, rsp_zero, ez);
        chk({tag, "_id"}, rsp_id, id[0]);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, cnt;
        logic [3:0] ids;
        logic [3:0] exp_ids;

        // Reset state
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_fields", {rsp_id, rsp_zero, rsp_carry, rsp_s}, 11'h000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("add", 0, 8'h3C, 8'h14, 1'b0, 8'h50, 1'b0, 1'b0);

        // Reset asserted during EXEC
        req0_a = 8'h11; req0_b = 8'h22; req_sub = 2'b00; req_valid = 2'b01;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 2'b00);
        chk("midrst_rsp_s", rsp_s, 8'h00);
        chk("midrst_flags", {rsp_id, rsp_zero, rsp_carry}, 3'b000);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b1;

        run_op("sub_eq", 1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1);
        run_op("sub_borrow", 0, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("ovf", 1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);

        // Contention: both requesters valid for four operations
        req0_a = 8'h01; req0_b = 8'h02; req1_a = 8'h10; req1_b = 8'h20;
        req_sub = 2'b00; req_valid = 2'b11; rsp_ready = 1'b1;
        cnt = 0; n = 0; ids = '0;
        while (cnt < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (rsp_valid && rsp_ready) begin
                ids[cnt] = rsp_id;
                cnt++;
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("contention_count", cnt, 4);
`ifdef ADDSUB_ARB_ROUND_ROBIN_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        chk("contention_ids", ids, exp_ids);
        @(posedge clk); #1;

        // Backpressure: the result is held for five cycles
        rsp_ready = 1'b0;
        req0_a = 8'h9A; req0_b = 8'h21; req_sub = 2'b01; req_valid = 2'b01;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 2'b11;
        req0_a = 8'($urandom); req1_a = 8'($urandom);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_req_ready", req_ready, 2'b00);
            chk("bp_fields", {rsp_id, rsp_zero, rsp_carry, rsp_s}, {3'b001, 8'h79});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_release_valid", rsp_valid, 1'b1);
        chk("bp_release_ready", req_ready, 2'b00);
        @(negedge clk);
        chk("bp_idle_valid", rsp_valid, 1'b0);
        chk("bp_idle_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic. The monitor checks every cycle.
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            req_sub = 2'($urandom);
            if (i % 40 < 4) begin
                req0_a = 8'($urandom_range(0, 3) * 85); req0_b = req0_a;
                req1_a = 8'hFF; req1_b = 8'h01;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
